// File: rtl/mux2a1_cond_tx_pkg.sv
// ============================================================================
// Module      : mux2a1_cond_tx_pkg
// Description : Shared defaults and types for the Tx 2:1 interleaving mux and
//               its per-lane FIFO (also usable by the matching Rx demux).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux2a1_cond_tx_pkg;

    localparam int unsigned WIDTH_DEF    = 8;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam logic [7:0]  DATA_OUT_RST = 8'h00;

    typedef enum logic {
        SEL_LANE0 = 1'b0,
        SEL_LANE1 = 1'b1
    } sel_e;

    function automatic sel_e next_lane(input sel_e cur);
        return (cur == SEL_LANE0) ? SEL_LANE1 : SEL_LANE0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2a1_cond_tx_fifo_sync_tx.sv
// ============================================================================
// Module      : fifo_sync_tx
// Description : Single-clock FIFO, synchronous active-low reset, no bypass:
//               a word pushed into an empty FIFO is poppable one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_tx
    import mux2a1_cond_tx_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_4f) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/mux2a1_cond_tx.sv
// ============================================================================
// Module      : mux2a1_cond_tx
// Description : Tx 2:1 interleaver; emits lane0, lane1, lane0, ... in strict
//               order from two skew-absorbing lane FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2a1_cond_tx
    import mux2a1_cond_tx_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic             valid0,
    input  logic [WIDTH-1:0] data_in0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data_in1,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             full0,
    output logic             full1,
    output logic             overflow
);

    logic [WIDTH-1:0] fifo_dout0, fifo_dout1;
    logic             fifo_full0, fifo_full1;
    logic             empty0, empty1;
    logic [CW-1:0]    count0, count1;
    logic             pop0, pop1;

    sel_e             sel_q, sel_d;
    logic             valid_out_q, valid_out_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             overflow_q, overflow_d;

    fifo_sync_tx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .push     (valid0),
        .pop      (pop0),
        .data_in  (data_in0),
        .data_out (fifo_dout0),
        .full     (fifo_full0),
        .empty    (empty0),
        .count    (count0)
    );

    fifo_sync_tx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .push     (valid1),
        .pop      (pop1),
        .data_in  (data_in1),
        .data_out (fifo_dout1),
        .full     (fifo_full1),
        .empty    (empty1),
        .count    (count1)
    );

    // Only the selected lane may pop; never skip ahead to the other lane.
    assign pop0 = (sel_q == SEL_LANE0) && !empty0;
    assign pop1 = (sel_q == SEL_LANE1) && !empty1;

    assign full0     = (count0 == CW'(DEPTH));
    assign full1     = (count1 == CW'(DEPTH));
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;

    always_comb begin
        valid_out_d = 1'b0;
        data_out_d  = WIDTH'(DATA_OUT_RST);
        sel_d       = sel_q;
        overflow_d  = overflow_q
                    | (valid0 && fifo_full0 && !pop0)
                    | (valid1 && fifo_full1 && !pop1);
        if (pop0) begin
            valid_out_d = 1'b1;
            data_out_d  = fifo_dout0;
            sel_d       = next_lane(sel_q);
        end else if (pop1) begin
            valid_out_d = 1'b1;
            data_out_d  = fifo_dout1;
            sel_d       = next_lane(sel_q);
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            sel_q       <= SEL_LANE0;
            valid_out_q <= 1'b0;
            data_out_q  <= WIDTH'(DATA_OUT_RST);
            overflow_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

`default_nettype wire
